// File: rtl/musa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : musa_pkg
// Description : Shared widths, reset PC and prefetch queue entry type for the
//               MUSA instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package musa_pkg;

    localparam int              MUSA_ADDR_W   = 18;
    localparam int              MUSA_INSTR_W  = 32;
    localparam logic [17:0]     MUSA_RESET_PC = 18'h0;

    // One buffered instruction, tagged with the word address it came from.
    typedef struct packed {
        logic [MUSA_ADDR_W-1:0]  pc;
        logic [MUSA_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential word address; wraps silently at the top of the address space.
    function automatic logic [MUSA_ADDR_W-1:0] next_pc(input logic [MUSA_ADDR_W-1:0] pc);
        return pc + {{(MUSA_ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/musa_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : musa_fetch_queue
// Description : Small synchronous FIFO of {pc, instr} entries. The head is
//               read straight out of the storage flops, so it is stable
//               whenever the queue is not popped. Flush empties the queue
//               and wins over push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module musa_fetch_queue
    import musa_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    fetch_entry_t     r_mem [DEPTH];

    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];

    // A pop on an empty queue is meaningless; a push into a full queue is only
    // legal when the head leaves in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The issue logic upstream must never let the queue overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));

endmodule
`default_nettype wire

// File: rtl/musa_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : musa_fetch_unit
// Description : Instruction fetch stage. Issues reads to a one-cycle-latency
//               instruction memory, tags returned words with their PC, buffers
//               them in a prefetch queue and presents them to decode over a
//               valid/ready handshake. Supports redirect (flush) and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module musa_fetch_unit
    import musa_pkg::*;
#(
    parameter int                ADDR_W      = MUSA_ADDR_W,
    parameter int                INSTR_W     = MUSA_INSTR_W,
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = MUSA_RESET_PC
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [ADDR_W-1:0]             imem_addr,
    output logic                          imem_rd_en,
    input  logic [INSTR_W-1:0]            imem_q,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    input  logic                          halt,
    output logic                          instr_valid,
    output logic [INSTR_W-1:0]            instr,
    output logic [ADDR_W-1:0]             instr_pc,
    input  logic                          instr_ready,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    logic [OCC_W-1:0]  w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    // Committed slots: words already queued plus the one still coming back
    // from memory. No credit is taken for a pop happening this cycle.
    assign w_occupancy = {1'b0, queue_count} + {{CNT_W{1'b0}}, r_inflight};

    // rst is in the issue term so the read strobe is low while reset is held.
    assign w_issue = !rst && !halt && !redirect_valid && !w_full
                   && (w_occupancy < OCC_W'(QUEUE_DEPTH));

    assign imem_rd_en = w_issue;
    assign imem_addr  = r_fetch_pc;

    // A returning word is dropped if a redirect flushes in the same cycle.
    assign w_push            = r_inflight && !redirect_valid;
    assign w_push_data.pc    = r_inflight_pc;
    assign w_push_data.instr = imem_q;
    assign w_pop             = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = !w_empty;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

    // Fetch PC and the single outstanding memory read; redirect overrides all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= redirect_pc;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= next_pc(r_fetch_pc);
            end
        end
    end

    musa_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .count     (queue_count),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_musa_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_musa_fetch_unit
// Description : Self-checking bench for musa_fetch_unit: a queue-level model
//               of the fetch stage compared every cycle, plus directed
//               literal checks at key points of each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_musa_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_q = '0;
    logic        redirect_valid = 1'b0;
    logic [17:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [17:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [2:0]  queue_count;

    int n_vec = 0;
    int n_err = 0;

    // Model state: next fetch address, the outstanding read, queued PCs.
    logic [17:0] m_pc = 18'h0;
    bit          m_infl = 1'b0;
    logic [17:0] m_infl_pc = 18'h0;
    logic [17:0] m_q [$];

    musa_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .queue_count    (queue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return {14'b0, a} ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: data one cycle after a read strobe.
    always @(posedge clk) begin
        if (imem_rd_en) imem_q <= mem_word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = 18'h0;
        m_infl    = 1'b0;
        m_infl_pc = 18'h0;
        m_q.delete();
    endtask

    always @(posedge rst) model_reset();

    // Per-cycle compare against the model, then advance the model one clock.
    always @(negedge clk) begin
        bit exp_rd;
        if (rst) begin
            model_reset();
            check("rst_rd_en", {31'b0, imem_rd_en}, 32'd0);
            check("rst_addr", {14'b0, imem_addr}, 32'd0);
            check("rst_valid", {31'b0, instr_valid}, 32'd0);
            check("rst_count", {29'b0, queue_count}, 32'd0);
        end else begin
            exp_rd = !halt && !redirect_valid && ((m_q.size() + int'(m_infl)) < 4);
            check("m_rd_en", {31'b0, imem_rd_en}, {31'b0, exp_rd});
            if (exp_rd) check("m_addr", {14'b0, imem_addr}, {14'b0, m_pc});
            check("m_valid", {31'b0, instr_valid}, {31'b0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                check("m_instr_pc", {14'b0, instr_pc}, {14'b0, m_q[0]});
                check("m_instr", instr, mem_word(m_q[0]));
            end
            check("m_count", {29'b0, queue_count}, m_q.size());
            if (redirect_valid) begin
                m_q.delete();
                m_infl = 1'b0;
                m_pc   = redirect_pc;
            end else begin
                if (instr_ready && m_q.size() != 0) void'(m_q.pop_front());
                if (m_infl) m_q.push_back(m_infl_pc);
                m_infl = exp_rd;
                if (exp_rd) begin
                    m_infl_pc = m_pc;
                    m_pc      = m_pc + 18'd1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // ---------------- Backpressure from reset, then drain ----------------
        repeat (2) cyc();
        rst = 1'b0;                                   // C0
        at_neg();
        check("A_c0_rd_en", {31'b0, imem_rd_en}, 32'd1);
        check("A_c0_addr", {14'b0, imem_addr}, 32'h0);
        check("A_c0_valid", {31'b0, instr_valid}, 32'd0);
        cyc(); cyc();                                 // C2
        at_neg();
        check("A_c2_valid", {31'b0, instr_valid}, 32'd1);
        check("A_c2_pc", {14'b0, instr_pc}, 32'h0);
        check("A_c2_instr", instr, 32'hA5A5_0000);
        repeat (8) cyc();                             // C10
        at_neg();
        check("A_sat_count", {29'b0, queue_count}, 32'd4);
        check("A_sat_rd_en", {31'b0, imem_rd_en}, 32'd0);
        check("A_sat_head", {14'b0, instr_pc}, 32'h0);
        cyc();
        instr_ready = 1'b1;                           // drain
        at_neg();
        check("A_d0_pc", {14'b0, instr_pc}, 32'h0);
        check("A_d0_rd_en", {31'b0, imem_rd_en}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            at_neg();
            check("A_drain_pc", {14'b0, instr_pc}, i);
        end
        repeat (4) cyc();

        // ---------------- Redirect with 3 queued + 1 in flight ----------------
        rst = 1'b1;
        instr_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;                                   // C0
        repeat (4) cyc();                             // C4 = T
        redirect_valid = 1'b1;
        redirect_pc    = 18'h0_0100;
        instr_ready    = 1'b1;
        at_neg();
        check("B_t_count", {29'b0, queue_count}, 32'd3);
        check("B_t_rd_en", {31'b0, imem_rd_en}, 32'd0);
        cyc();                                        // T+1
        redirect_valid = 1'b0;
        at_neg();
        check("B_t1_count", {29'b0, queue_count}, 32'd0);
        check("B_t1_rd_en", {31'b0, imem_rd_en}, 32'd1);
        check("B_t1_addr", {14'b0, imem_addr}, 32'h100);
        cyc();                                        // T+2
        at_neg();
        check("B_t2_valid", {31'b0, instr_valid}, 32'd0);
        cyc();                                        // T+3
        at_neg();
        check("B_t3_valid", {31'b0, instr_valid}, 32'd1);
        check("B_t3_pc", {14'b0, instr_pc}, 32'h100);
        check("B_t3_instr", instr, 32'hA5A5_0100);
        repeat (2) cyc();

        // ---------------- Address wrap ----------------
        redirect_valid = 1'b1;
        redirect_pc    = 18'h3FFFE;
        cyc();
        redirect_valid = 1'b0;
        cyc(); cyc();                                 // T+3
        at_neg();
        check("C_pc0", {14'b0, instr_pc}, 32'h3FFFE);
        check("C_instr0", instr, 32'hA5A6_FFFE);
        cyc(); at_neg();
        check("C_pc1", {14'b0, instr_pc}, 32'h3FFFF);
        check("C_instr1", instr, 32'hA5A6_FFFF);
        cyc(); at_neg();
        check("C_pc2", {14'b0, instr_pc}, 32'h0);
        cyc(); at_neg();
        check("C_pc3", {14'b0, instr_pc}, 32'h1);

        // ---------------- Halt, redirect while halted ----------------
        cyc();
        halt = 1'b1;                                  // H
        at_neg();
        check("D_h_rd_en", {31'b0, imem_rd_en}, 32'd0);
        cyc(); at_neg();                              // H+1: last in-flight word
        check("D_h1_valid", {31'b0, instr_valid}, 32'd1);
        cyc(); at_neg();                              // H+2
        check("D_h2_valid", {31'b0, instr_valid}, 32'd0);
        check("D_h2_count", {29'b0, queue_count}, 32'd0);
        cyc();                                        // H+3
        redirect_valid = 1'b1;
        redirect_pc    = 18'h0_0020;
        cyc();                                        // H+4
        redirect_valid = 1'b0;
        at_neg();
        check("D_h4_rd_en", {31'b0, imem_rd_en}, 32'd0);
        cyc();                                        // H+5
        halt = 1'b0;
        at_neg();
        check("D_h5_rd_en", {31'b0, imem_rd_en}, 32'd1);
        check("D_h5_addr", {14'b0, imem_addr}, 32'h20);
        cyc(); cyc(); at_neg();                       // H+7
        check("D_h7_valid", {31'b0, instr_valid}, 32'd1);
        check("D_h7_pc", {14'b0, instr_pc}, 32'h20);

        // ---------------- Mid-stream reset with a read in flight ----------------
        repeat (3) cyc();                             // X
        at_neg();
        check("E_x_rd_en", {31'b0, imem_rd_en}, 32'd1);
        cyc();                                        // X+1: stale word on imem_q
        rst = 1'b1;
        #1;
        check("E_async_rd_en", {31'b0, imem_rd_en}, 32'd0);
        check("E_async_addr", {14'b0, imem_addr}, 32'h0);
        check("E_async_valid", {31'b0, instr_valid}, 32'd0);
        check("E_async_instr", instr, 32'h0);
        check("E_async_pc", {14'b0, instr_pc}, 32'h0);
        check("E_async_count", {29'b0, queue_count}, 32'd0);
        #1;
        rst = 1'b0;
        at_neg();
        check("E_x1_rd_en", {31'b0, imem_rd_en}, 32'd1);
        check("E_x1_addr", {14'b0, imem_addr}, 32'h0);
        cyc(); at_neg();                              // X+2
        check("E_x2_count", {29'b0, queue_count}, 32'd0);
        check("E_x2_valid", {31'b0, instr_valid}, 32'd0);
        cyc(); at_neg();                              // X+3
        check("E_x3_valid", {31'b0, instr_valid}, 32'd1);
        check("E_x3_pc", {14'b0, instr_pc}, 32'h0);
        check("E_x3_instr", instr, 32'hA5A5_0000);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
